// File: rtl/tmds_timing_pkg.sv
// Shared timing constants (1650x750 720p defaults) and a small range-decode helper
// for the TMDS timing generator.
package tmds_timing_pkg;

   localparam int DEF_H_TOTAL     = 1650;
   localparam int DEF_V_TOTAL     = 750;
   localparam int DEF_HS_START    = 110;
   localparam int DEF_HS_END      = 149;
   localparam int DEF_VS_START    = 0;
   localparam int DEF_VS_END      = 4;
   localparam int DEF_HA_START    = 221;
   localparam int DEF_HA_END      = 1499;
   localparam int DEF_VA_START    = 21;
   localparam int DEF_VA_END      = 739;
   localparam int DEF_ADE_LEN     = 32;
   localparam int DEF_ADE_A_START = 59;
   localparam int DEF_ADE_B_START = 93;
   localparam int DEF_ADE_PERIOD  = 15;
   localparam int DEF_ADE_LATCH   = 1502;
   localparam int DEF_CNT_W       = 11;
   localparam int DEF_NUM_W       = 4;

   // Signed int compare keeps a zero lower bound from becoming a constant-true unsigned test.
   function automatic logic in_range(input int value, input int lo, input int hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/tmds_timing_gen_ade_pkt_counter.sv
// Audio data-enable packet counter: counts completed ADE_LEN-cycle packets and latches
// the (saturating) total into ade_num once per line, discarding any partial packet.
module ade_pkt_counter #(
   parameter int ADE_LEN = 32,
   parameter int NUM_W   = 4
) (
   input  logic             fifo_clk,
   input  logic             sys_rst,
   input  logic             en,
   input  logic             ade,
   input  logic             latch,
   output logic [NUM_W-1:0] ade_num
);

   localparam int CYC_W = ($clog2(ADE_LEN) > 5) ? $clog2(ADE_LEN) : 5;

   logic [CYC_W-1:0] cyc_cnt;
   logic [NUM_W-1:0] pkt_cnt;

   // Latch takes priority so a packet finishing on the latch cycle is dropped with the partial one.
   always_ff @(posedge fifo_clk) begin
      if (sys_rst) begin
         cyc_cnt <= '0;
         pkt_cnt <= '0;
         ade_num <= '0;
      end else if (en) begin
         if (latch) begin
            ade_num <= pkt_cnt;
            pkt_cnt <= '0;
            cyc_cnt <= '0;
         end else if (ade) begin
            if (cyc_cnt == CYC_W'(ADE_LEN - 1)) begin
               cyc_cnt <= '0;
               if (pkt_cnt != '1) begin
                  pkt_cnt <= pkt_cnt + 1'b1;
               end
            end else begin
               cyc_cnt <= cyc_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tmds_timing_gen.sv
// TMDS video/audio timing generator: raster counters plus registered sync, video and
// audio enables. Audio data-enable logic exists only when TMDS_TIMING_ADE_EN is defined.
module tmds_timing_gen
   import tmds_timing_pkg::*;
#(
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter int V_TOTAL     = DEF_V_TOTAL,
   parameter int HS_START    = DEF_HS_START,
   parameter int HS_END      = DEF_HS_END,
   parameter int VS_START    = DEF_VS_START,
   parameter int VS_END      = DEF_VS_END,
   parameter int HA_START    = DEF_HA_START,
   parameter int HA_END      = DEF_HA_END,
   parameter int VA_START    = DEF_VA_START,
   parameter int VA_END      = DEF_VA_END,
   parameter int ADE_LEN     = DEF_ADE_LEN,
   parameter int ADE_A_START = DEF_ADE_A_START,
   parameter int ADE_B_START = DEF_ADE_B_START,
   parameter int ADE_PERIOD  = DEF_ADE_PERIOD,
   parameter int ADE_LATCH   = DEF_ADE_LATCH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int NUM_W       = DEF_NUM_W
) (
   input  logic             fifo_clk,
   input  logic             sys_rst,
   input  logic             en,
   output logic [CNT_W-1:0] hcnt,
   output logic [CNT_W-1:0] vcnt,
   output logic             hs,
   output logic             vs,
   output logic             vde,
   output logic             ade,
   output logic [NUM_W-1:0] ade_num,
   output logic             frame_start
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic h_wrap;
   assign h_wrap = (hcnt == H_LAST);

   always_ff @(posedge fifo_clk) begin
      if (sys_rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (en) begin
         if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   // Decodes look at the current counters, so every output trails its raster position by one cycle.
   always_ff @(posedge fifo_clk) begin
      if (sys_rst) begin
         hs          <= 1'b0;
         vs          <= 1'b0;
         vde         <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         hs          <= in_range(int'(hcnt), HS_START, HS_END);
         vs          <= in_range(int'(vcnt), VS_START, VS_END);
         vde         <= in_range(int'(hcnt), HA_START, HA_END) &&
                        in_range(int'(vcnt), VA_START, VA_END);
         frame_start <= (hcnt == '0) && (vcnt == '0);
      end else begin
         frame_start <= 1'b0;
      end
   end

`ifdef TMDS_TIMING_ADE_EN
   localparam int PH_W = (ADE_PERIOD > 1) ? $clog2(ADE_PERIOD) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(ADE_PERIOD - 1);

   logic [PH_W-1:0] phase;
   logic            extra_line;

   // Phase restarts with each frame so the extra-window lines land at the same vcnt every frame.
   always_ff @(posedge fifo_clk) begin
      if (sys_rst) begin
         phase <= '0;
      end else if (en && h_wrap) begin
         if ((vcnt == V_LAST) || (phase == PH_LAST)) begin
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   assign extra_line = (phase == PH_LAST) || (vcnt == '0);

   always_ff @(posedge fifo_clk) begin
      if (sys_rst) begin
         ade <= 1'b0;
      end else if (en) begin
         ade <= in_range(int'(hcnt), ADE_A_START, ADE_A_START + ADE_LEN - 1) ||
                (extra_line && in_range(int'(hcnt), ADE_B_START, ADE_B_START + ADE_LEN - 1));
      end
   end

   ade_pkt_counter #(
      .ADE_LEN (ADE_LEN),
      .NUM_W   (NUM_W)
   ) u_ade_pkt_counter (
      .fifo_clk (fifo_clk),
      .sys_rst  (sys_rst),
      .en       (en),
      .ade      (ade),
      .latch    (hcnt == CNT_W'(ADE_LATCH)),
      .ade_num  (ade_num)
   );
`else
   localparam int ade_cfg_unused = ADE_LEN + ADE_A_START + ADE_B_START + ADE_PERIOD + ADE_LATCH;

   assign ade     = 1'b0;
   assign ade_num = '0;
`endif

endmodule

// File: tb/tb_tmds_timing_gen.sv
// Scoreboard bench for tmds_timing_gen on a scaled raster; audio checks follow
// whether TMDS_TIMING_ADE_EN is defined for the build.
module tb_tmds_timing_gen;

   localparam int H_TOTAL = 160, V_TOTAL = 40;
   localparam int HS_START = 10, HS_END = 19, VS_START = 0, VS_END = 2;
   localparam int HA_START = 50, HA_END = 149, VA_START = 5, VA_END = 35;
   localparam int ADE_LEN = 8, ADE_A_START = 20, ADE_B_START = 32, ADE_PERIOD = 5;
   localparam int ADE_LATCH = 152, CNT_W = 11, NUM_W = 4;
`ifdef TMDS_TIMING_ADE_EN
   localparam bit ADE_ON = 1'b1;
`else
   localparam bit ADE_ON = 1'b0;
`endif

   logic             fifo_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             en = 1'b0;
   logic [CNT_W-1:0] hcnt, vcnt, hcnt_s, vcnt_s;
   logic             hs, vs, vde, ade, frame_start;
   logic             hs_s, vs_s, vde_s, ade_s, frame_start_s;
   logic [NUM_W-1:0] ade_num;
   logic [0:0]       ade_num1;
   logic [31:0]      obs_vec, obs1_vec;

   always #5 fifo_clk = ~fifo_clk;

   tmds_timing_gen #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HS_START(HS_START), .HS_END(HS_END),
      .VS_START(VS_START), .VS_END(VS_END), .HA_START(HA_START), .HA_END(HA_END),
      .VA_START(VA_START), .VA_END(VA_END), .ADE_LEN(ADE_LEN), .ADE_A_START(ADE_A_START),
      .ADE_B_START(ADE_B_START), .ADE_PERIOD(ADE_PERIOD), .ADE_LATCH(ADE_LATCH),
      .CNT_W(CNT_W), .NUM_W(NUM_W)
   ) dut (
      .fifo_clk(fifo_clk), .sys_rst(sys_rst), .en(en), .hcnt(hcnt), .vcnt(vcnt),
      .hs(hs), .vs(vs), .vde(vde), .ade(ade), .ade_num(ade_num), .frame_start(frame_start)
   );

   // Second copy with a one-bit packet count to exercise saturation on two-window lines.
   tmds_timing_gen #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HS_START(HS_START), .HS_END(HS_END),
      .VS_START(VS_START), .VS_END(VS_END), .HA_START(HA_START), .HA_END(HA_END),
      .VA_START(VA_START), .VA_END(VA_END), .ADE_LEN(ADE_LEN), .ADE_A_START(ADE_A_START),
      .ADE_B_START(ADE_B_START), .ADE_PERIOD(ADE_PERIOD), .ADE_LATCH(ADE_LATCH),
      .CNT_W(CNT_W), .NUM_W(1)
   ) dut_sat (
      .fifo_clk(fifo_clk), .sys_rst(sys_rst), .en(en), .hcnt(hcnt_s), .vcnt(vcnt_s),
      .hs(hs_s), .vs(vs_s), .vde(vde_s), .ade(ade_s), .ade_num(ade_num1),
      .frame_start(frame_start_s)
   );

   assign obs_vec  = {hcnt, vcnt, hs, vs, vde, ade, ade_num, frame_start, ade_num1};
   assign obs1_vec = {hcnt_s, vcnt_s, hs_s, vs_s, vde_s, ade_s, 4'b0000, frame_start_s, 1'b0};

   int mh, mv, mnum, mnum1;
   logic mhs, mvs, mvde, made, mfs;
   logic [31:0] exp_q[$];
   logic [31:0] exp_vec;
   int vectors, miscompares;
   bit tally;
   int hs_cnt, vs_cnt, vde_cnt, ade_cnt, fs_cnt;

   function automatic bit two_window_line(input int v);
      return (v % ADE_PERIOD == ADE_PERIOD - 1) || (v == 0);
   endfunction

   function automatic bit in_ade_window(input int h, input int v);
      return (h >= ADE_A_START && h <= ADE_A_START + ADE_LEN - 1) ||
             (two_window_line(v) && h >= ADE_B_START && h <= ADE_B_START + ADE_LEN - 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock: check the previous cycle's outputs, drive new inputs, advance the model.
   task automatic applyStimulus(input logic rst_val, input logic en_val);
      @(negedge fifo_clk);
      if (exp_q.size() > 0) begin
         exp_vec = exp_q.pop_front();
         checkOutput("cycle", obs_vec, exp_vec);
         checkOutput("cycle_sat_dut", obs1_vec, exp_vec & ~32'h0000_003D);
      end
      if (tally) begin
         hs_cnt  += int'(hs);
         vs_cnt  += int'(vs);
         vde_cnt += int'(vde);
         ade_cnt += int'(ade);
         fs_cnt  += int'(frame_start);
      end
      sys_rst = rst_val;
      en      = en_val;
      if (rst_val) begin
         mh = 0; mv = 0; mnum = 0; mnum1 = 0;
         mhs = 0; mvs = 0; mvde = 0; made = 0; mfs = 0;
      end else if (en_val) begin
         mhs  = (mh >= HS_START && mh <= HS_END);
         mvs  = (mv >= VS_START && mv <= VS_END);
         mvde = (mh >= HA_START && mh <= HA_END && mv >= VA_START && mv <= VA_END);
         made = ADE_ON && in_ade_window(mh, mv);
         mfs  = (mh == 0 && mv == 0);
         if (ADE_ON && mh == ADE_LATCH) begin
            mnum  = two_window_line(mv) ? 2 : 1;
            mnum1 = 1;
         end
         mh = mh + 1;
         if (mh == H_TOTAL) begin
            mh = 0;
            mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
         end
      end else begin
         mfs = 0;
      end
      exp_q.push_back({11'(mh), 11'(mv), mhs, mvs, mvde, made, 4'(mnum), mfs, 1'(mnum1)});
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors = 0; miscompares = 0; tally = 0;
      hs_cnt = 0; vs_cnt = 0; vde_cnt = 0; ade_cnt = 0; fs_cnt = 0;

      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);

      // One full frame of decodes, tallied per output.
      tally = 1;
      for (int i = 0; i <= H_TOTAL * V_TOTAL; i++) applyStimulus(1'b0, 1'b1);
      tally = 0;
      checkOutput("hs_per_frame",  32'(hs_cnt),  32'd400);
      checkOutput("vs_per_frame",  32'(vs_cnt),  32'd480);
      checkOutput("vde_per_frame", 32'(vde_cnt), 32'd3100);
      checkOutput("ade_per_frame", 32'(ade_cnt), ADE_ON ? 32'd392 : 32'd0);
      checkOutput("fs_per_frame",  32'(fs_cnt),  32'd1);

      // Freeze mid-line, then resume.
      for (int i = 0; i < H_TOTAL * V_TOTAL && !(mh == 50 && mv == 10); i++) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("frozen_hcnt", 32'(hcnt), 32'd50);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("resume_hcnt", 32'(hcnt), 32'd51);

      // Reset mid-frame, then watch frame_start after the restart at (0,0).
      for (int i = 0; i < H_TOTAL * V_TOTAL && !(mh == 100 && mv == 30); i++) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_reset_all", obs_vec, 32'd0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_reset_fs_high", 32'(frame_start), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("post_reset_fs_low", 32'(frame_start), 32'd0);

      for (int i = 0; i < H_TOTAL * V_TOTAL + 200; i++) applyStimulus(1'b0, 1'b1);
      @(negedge fifo_clk);
      if (exp_q.size() > 0) checkOutput("cycle_last", obs_vec, exp_q.pop_front());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tmds_timing_gen.md
TMDS_TIMING_GEN -- requirements
Module: tmds_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_TOTAL 1650: pixels per line; V_TOTAL 750: lines per frame
  HS_START 110, HS_END 149: hsync columns, inclusive; VS_START 0, VS_END 4: vsync lines, inclusive
  HA_START 221, HA_END 1499: active columns; VA_START 21, VA_END 739: active lines
  ADE_LEN 32: cycles per audio packet; ADE_A_START 59: per-line packet start column; ADE_B_START 93: extra packet start column
  ADE_PERIOD 15: lines per extra-packet cycle; ADE_LATCH 1502: column where ade_num latches; CNT_W 11: counter width; NUM_W 4: ade_num width
REQ-002 Ports (name, direction, width, meaning):
  fifo_clk  in  1  pixel clock, sole clock
  sys_rst  in  1  synchronous active-high reset
  en  in  1  count enable; low freezes all state
  hcnt  out  CNT_W  horizontal counter
  vcnt  out  CNT_W  vertical counter
  hs, vs  out  1  sync pulses, active-high
  vde  out  1  video data enable
  ade  out  1  audio data enable
  ade_num  out  NUM_W  completed ADE packets in the last latch interval
  frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0
REQ-003 One clock domain; reset is synchronous, active-high, on sys_rst sampled at posedge fifo_clk.

Function
REQ-004 hcnt SHALL count 0..H_TOTAL-1 when en=1 and wrap to 0; vcnt SHALL increment on each hcnt wrap and wrap to 0 after V_TOTAL-1.
REQ-005 hs, vs, vde, ade SHALL be registered decodes of the current hcnt/vcnt, asserted one cycle after the counters hold the qualifying value.
REQ-006 hs=1 iff HS_START<=hcnt<=HS_END; vs=1 iff VS_START<=vcnt<=VS_END; vde=1 iff HA_START<=hcnt<=HA_END and VA_START<=vcnt<=VA_END.
REQ-007 A line-phase counter SHALL count 0..ADE_PERIOD-1, advance on each hcnt wrap, and clear when vcnt wraps to 0.
REQ-008 ade=1 for hcnt in [ADE_A_START, ADE_A_START+ADE_LEN-1] on every line; additionally for [ADE_B_START, ADE_B_START+ADE_LEN-1] when phase=ADE_PERIOD-1 or vcnt=0.
REQ-009 A 5-bit-or-wider cycle counter SHALL count ade-high cycles; on reaching ADE_LEN-1 with ade=1 it clears and the packet counter increments, saturating at 2^NUM_W-1.
REQ-010 When hcnt=ADE_LATCH: ade_num <= packet counter; packet and cycle counters clear; latch wins over a simultaneous increment, and the partial packet is discarded.
REQ-011 frame_start SHALL be registered, high for exactly one cycle per frame, aligned with hs/vs latency.
REQ-012 With en=0, counters, phase, ade counters and all outputs SHALL hold; frame_start SHALL be 0.

Reset
REQ-013 On sys_rst: hcnt=0, vcnt=0, phase=0, ade counters=0, hs=vs=vde=ade=0, ade_num=0, frame_start=0; reset mid-frame restarts at (0,0) on the next cycle; sys_rst overrides en.

Configuration
REQ-014 Macro TMDS_TIMING_ADE_EN: defined -> REQ-007..REQ-010 logic present; undefined -> ade and ade_num tied 0, phase and ade counter logic removed, video timing unchanged.

Structure
REQ-015 Default timing constants (1650x750 720p) and CNT_W/NUM_W defaults SHALL reside in shared package tmds_timing_pkg.
REQ-016 ADE packet counting (REQ-009/010) SHALL be sub-module ade_pkt_counter; counters and decodes stay in the top.

Verification
REQ-017 Defaults, reset released, en=1: hs high for 40 cycles per line starting one cycle after hcnt=110; vs high for lines 0..4; vde high 1279 cycles per active line.
REQ-018 Count ade over one frame: 750 + 50 extra + 1 (vcnt=0) windows = 801 packets of 32 cycles each; each ade_num latched on lines with one window = 1, on extra-window lines = 2.
REQ-019 Force ade_num saturation with NUM_W=1 and two windows -> ade_num=1, no wrap to 0.
REQ-020 Hold en=0 for 100 cycles mid-line at hcnt=500 -> all outputs frozen, resume at hcnt=501 when en returns.
REQ-021 Assert sys_rst for 1 cycle at vcnt=300, hcnt=1000 -> next cycle hcnt=0, vcnt=0, all outputs 0, frame_start pulses 1 cycle after the following (0,0).
REQ-022 Build without TMDS_TIMING_ADE_EN -> ade=0 and ade_num=0 over a full frame; hs/vs/vde traces identical to REQ-017.
